// File: rtl/pipelined_array_multiplier.sv
// pipelined_array_multiplier
//   Exact X*Y multiplier, unsigned or two's-complement per transaction.
//   Partial-product row k is summed in stage floor(k*STAGES/WIDTH_X). The
//   last stage is the output register. All stages advance together whenever
//   the output slot is empty or being consumed.
//
//   Optional build macro: MULT_ACC_EN
//     When defined, z carries a running sum of products. The sum wraps modulo
//     2^(WIDTH_X+WIDTH_Y) and is restarted by a transaction that has acc_clr
//     set. When undefined, acc_clr is carried but ignored, and z is the plain
//     product.
module pipelined_array_multiplier #(
    parameter int WIDTH_X = 4,
    parameter int WIDTH_Y = 5,
    parameter int STAGES  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_X-1:0]         x,
    input  logic [WIDTH_Y-1:0]         y,
    input  logic                       is_signed,
    input  logic                       acc_clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_X+WIDTH_Y-1:0] z
);

    localparam int WZ   = WIDTH_X + WIDTH_Y;
    localparam int LAST = STAGES - 1;

    // Sum of the partial-product rows owned by stage s, modulo 2^WZ.
    // Signed mode sign-extends y inside every row and subtracts the row of
    // the x sign bit; because the exact result fits in WZ bits, the modular
    // sum is the exact product.
    function automatic logic [WZ-1:0] stage_rows(
        input int                 s,
        input logic [WIDTH_X-1:0] fx,
        input logic [WIDTH_Y-1:0] fy,
        input logic               fs
    );
        logic [WZ-1:0] ext_y;
        logic [WZ-1:0] row;
        logic [WZ-1:0] sum;
        ext_y = fs ? {{WIDTH_X{fy[WIDTH_Y-1]}}, fy} : {{WIDTH_X{1'b0}}, fy};
        sum   = '0;
        row   = '0;
        for (int k = 0; k < WIDTH_X; k++) begin
            if ((k * STAGES) / WIDTH_X == s) begin
                row = fx[k] ? (ext_y << k) : '0;
                if (fs && (k == WIDTH_X - 1)) begin
                    sum = sum - row;
                end else begin
                    sum = sum + row;
                end
            end
        end
        return sum;
    endfunction

    logic w_advance;

    // Global stall: everything moves when the output slot is free or drained.
    always_comb begin
        w_advance = ~out_valid | out_ready;
        in_ready  = w_advance;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic               r_vld;
        logic [WZ-1:0]      r_sum;
        logic [WIDTH_X-1:0] r_x;
        logic [WIDTH_Y-1:0] r_y;
        logic               r_sgn;
        logic               r_clr;

        logic               w_vld_in;
        logic [WZ-1:0]      w_sum_in;
        logic [WIDTH_X-1:0] w_x_in;
        logic [WIDTH_Y-1:0] w_y_in;
        logic               w_sgn_in;
        logic               w_clr_in;
        logic [WZ-1:0]      w_sum_nxt;

        if (s == 0) begin : g_head
            // Stage 0 takes the new operands; no transfer means a bubble.
            always_comb begin
                w_vld_in = in_valid;
                w_sum_in = '0;
                w_x_in   = x;
                w_y_in   = y;
                w_sgn_in = is_signed;
                w_clr_in = acc_clr;
            end
        end else begin : g_body
            // Later stages take the previous stage's carried transaction.
            always_comb begin
                w_vld_in = g_stage[s-1].r_vld;
                w_sum_in = g_stage[s-1].r_sum;
                w_x_in   = g_stage[s-1].r_x;
                w_y_in   = g_stage[s-1].r_y;
                w_sgn_in = g_stage[s-1].r_sgn;
                w_clr_in = g_stage[s-1].r_clr;
            end
        end

        assign w_sum_nxt = w_sum_in + stage_rows(s, w_x_in, w_y_in, w_sgn_in);

        // Stage register: loads the incoming transaction (or bubble) on advance.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_sum <= '0;
                r_x   <= '0;
                r_y   <= '0;
                r_sgn <= 1'b0;
                r_clr <= 1'b0;
            end else if (w_advance) begin
                r_vld <= w_vld_in;
                r_sum <= w_sum_nxt;
                r_x   <= w_x_in;
                r_y   <= w_y_in;
                r_sgn <= w_sgn_in;
                r_clr <= w_clr_in;
            end
        end
    end

    // The final stage's operand copies have no consumer after it.
    logic w_unused_tail;
    assign w_unused_tail = ^{g_stage[LAST].r_x, g_stage[LAST].r_y,
                             g_stage[LAST].r_sgn, g_stage[LAST].r_clr};

    assign out_valid = g_stage[LAST].r_vld;

`ifdef MULT_ACC_EN
    logic [WZ-1:0] r_acc;

    // Running sum is updated as a valid product enters the output register,
    // so it appears on z with the same latency as a plain product would.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_advance && g_stage[LAST].w_vld_in) begin
            r_acc <= (g_stage[LAST].w_clr_in ? '0 : r_acc) + g_stage[LAST].w_sum_nxt;
        end
    end

    assign z = r_acc;
`else
    assign z = g_stage[LAST].r_sum;
`endif

endmodule
